// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 scancode-to-command decoder.
// Contents:
//   - prefix byte values
//   - 9-bit {ext,byte} scan keys of the mapped keys
//   - command codes
//   - FSM state encoding
package ps2_pkg;

  // Prefix bytes seen on the PS/2 wire
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Width of a scan key: extended flag prepended to the raw byte
  localparam int unsigned SCAN_W = 9;

  // Mapped scan keys, {ext, byte}
  localparam logic [SCAN_W-1:0] KEY_16   = 9'h016;
  localparam logic [SCAN_W-1:0] KEY_1E   = 9'h01E;
  localparam logic [SCAN_W-1:0] KEY_26   = 9'h026;
  localparam logic [SCAN_W-1:0] KEY_25   = 9'h025;
  localparam logic [SCAN_W-1:0] KEY_2E   = 9'h02E;
  localparam logic [SCAN_W-1:0] KEY_E075 = 9'h175;
  localparam logic [SCAN_W-1:0] KEY_E072 = 9'h172;

  // Command codes; 0 is reserved for "unmapped"
  localparam int unsigned CMD_UNMAPPED = 0;
  localparam int unsigned CMD_25       = 25;
  localparam int unsigned CMD_26       = 26;
  localparam int unsigned CMD_28       = 28;
  localparam int unsigned CMD_29       = 29;
  localparam int unsigned CMD_30       = 30;

  // Decoder FSM states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GOT_F0   = 2'd1,
    ST_GOT_E0   = 2'd2,
    ST_GOT_E0F0 = 2'd3
  } state_e;

endpackage : ps2_pkg

// File: rtl/ps2_cmd_fsm_if.sv
// Byte-in / command-out bundle of the PS/2 command decoder.
// Signals:
//   rx_done_tick : strobe, new byte on rx_data
//   rx_data      : scancode byte
//   cmd_code     : code of the last accepted make
//   cmd_valid    : pulse, new make accepted
//   cmd_release  : pulse, held key released
//   key_held     : level, a mapped key is held
//   err_tick     : pulse, prefix timeout abort
// Modports:
//   master : byte source / command consumer side
//   slave  : the decoder
interface ps2_cmd_fsm_if #(
  parameter int unsigned CODE_W = 5
) ();

  logic              rx_done_tick;
  logic [7:0]        rx_data;
  logic [CODE_W-1:0] cmd_code;
  logic              cmd_valid;
  logic              cmd_release;
  logic              key_held;
  logic              err_tick;

  modport master (
    output rx_done_tick,
    output rx_data,
    input  cmd_code,
    input  cmd_valid,
    input  cmd_release,
    input  key_held,
    input  err_tick
  );

  modport slave (
    input  rx_done_tick,
    input  rx_data,
    output cmd_code,
    output cmd_valid,
    output cmd_release,
    output key_held,
    output err_tick
  );

endinterface : ps2_cmd_fsm_if

// File: rtl/ps2_code_map.sv
// Combinational scan-key to command-code lookup.
// Ports:
//   scan_key_i : {ext, byte} scan key
//   code_o     : command code, 0 when the key is unmapped
module ps2_code_map
  import ps2_pkg::*;
#(
  parameter int unsigned CODE_W = 5
) (
  input  logic [SCAN_W-1:0] scan_key_i,
  output logic [CODE_W-1:0] code_o
);

  // Key table
  always_comb begin
    code_o = CODE_W'(CMD_UNMAPPED);
    case (scan_key_i)
      KEY_16:   code_o = CODE_W'(CMD_25);
      KEY_1E:   code_o = CODE_W'(CMD_25);
      KEY_26:   code_o = CODE_W'(CMD_25);
      KEY_25:   code_o = CODE_W'(CMD_26);
      KEY_2E:   code_o = CODE_W'(CMD_28);
      KEY_E075: code_o = CODE_W'(CMD_29);
      KEY_E072: code_o = CODE_W'(CMD_30);
      default:  code_o = CODE_W'(CMD_UNMAPPED);
    endcase
  end

endmodule : ps2_code_map

// File: rtl/ps2_cmd_fsm.sv
// PS/2 scancode-to-command decoder.
// Tracks the F0/E0 prefixes, filters typematic repeat, emits one-cycle
// make/release pulses and aborts a stalled prefix after TIMEOUT_CYC idle
// cycles.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high reset
//   bus   : slave side of ps2_cmd_fsm_if (byte in, command out)
// Parameters:
//   CODE_W      : command code width (>= 5)
//   EN_EXT      : 1 = honour the E0 prefix, 0 = E0 is an unmapped byte
//   TIMEOUT_CYC : idle cycles tolerated in a prefix state (>= 2)
//   CNT_W       : timeout counter width, 2**CNT_W > TIMEOUT_CYC
module ps2_cmd_fsm
  import ps2_pkg::*;
#(
  parameter int unsigned CODE_W      = 5,
  parameter int unsigned EN_EXT      = 1,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter int unsigned CNT_W       = 20
) (
  input  logic           clk,
  input  logic           reset,
  ps2_cmd_fsm_if.slave   bus
);

  localparam logic             EXT_ON   = (EN_EXT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SCAN_W-1:0]   last_scan_q, last_scan_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                valid_q, valid_d;
  logic                release_q, release_d;
  logic                held_q, held_d;
  logic                err_q, err_d;

  logic [SCAN_W-1:0]   scan_key_c;
  logic [CODE_W-1:0]   map_code_c;
  logic                make_c;
  logic                break_c;
  logic                match_c;

  // Extended flag comes from the prefix state the byte lands in
  assign scan_key_c = {(state_q == ST_GOT_E0) || (state_q == ST_GOT_E0F0),
                       bus.rx_data};

  // Same key as the one currently held
  assign match_c = held_q && (last_scan_q == scan_key_c);

  ps2_code_map #(
    .CODE_W (CODE_W)
  ) u_code_map (
    .scan_key_i (scan_key_c),
    .code_o     (map_code_c)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_scan_q <= '0;
      code_q      <= '0;
      valid_q     <= 1'b0;
      release_q   <= 1'b0;
      held_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_scan_q <= last_scan_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      release_q   <= release_d;
      held_q      <= held_d;
      err_q       <= err_d;
    end
  end

  // Next-state, timeout and make/break handling
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_scan_d = last_scan_q;
    code_d      = code_q;
    held_d      = held_q;
    valid_d     = 1'b0;
    release_d   = 1'b0;
    err_d       = 1'b0;
    make_c      = 1'b0;
    break_c     = 1'b0;

    if (bus.rx_done_tick) begin
      // A byte always wins over a coincident terminal count
      cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (bus.rx_data == PS2_BREAK) begin
            state_d = ST_GOT_F0;
          end else if (EXT_ON && (bus.rx_data == PS2_EXT)) begin
            state_d = ST_GOT_E0;
          end else begin
            make_c = 1'b1;
          end
        end
        ST_GOT_E0: begin
          if (bus.rx_data == PS2_BREAK) begin
            state_d = ST_GOT_E0F0;
          end else if (bus.rx_data != PS2_EXT) begin
            make_c  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_GOT_F0: begin
          if (bus.rx_data != PS2_BREAK) begin
            break_c = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_GOT_E0F0: begin
          if ((bus.rx_data != PS2_BREAK) && (bus.rx_data != PS2_EXT)) begin
            break_c = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Truncated prefix: drop it, keep the held key untouched
      state_d = ST_IDLE;
      cnt_d   = '0;
      err_d   = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Repeat of the held key is typematic and stays silent
    if (make_c && (map_code_c != '0) && !match_c) begin
      code_d      = map_code_c;
      valid_d     = 1'b1;
      held_d      = 1'b1;
      last_scan_d = scan_key_c;
    end

    if (break_c && match_c) begin
      held_d    = 1'b0;
      release_d = 1'b1;
    end
  end

  assign bus.cmd_code    = code_q;
  assign bus.cmd_valid   = valid_q;
  assign bus.cmd_release = release_q;
  assign bus.key_held    = held_q;
  assign bus.err_tick    = err_q;

endmodule : ps2_cmd_fsm

// File: doc/ps2_cmd_fsm.md
Name: ps2_cmd_fsm

Overview:
Sequential PS/2 scancode-to-command decoder. It sits after the PS/2 byte receiver and before the command consumers (display/temperature control).
- Tracks the F0 (break) and E0 (extended) prefixes.
- Filters typematic auto-repeat.
- Emits one-cycle make/release pulses with a registered command code.
- Recovers from truncated prefix sequences with a timeout.

Parameters:
- CODE_W, 5: command code width; must be >= 5 so every table value fits.
- EN_EXT, 1: 1 = handle the E0 extended prefix; 0 = treat E0 as an unmapped byte.
- TIMEOUT_CYC, 1000000: idle cycles allowed inside a prefix state before abort (10 ms at 100 MHz); must be >= 2.
- CNT_W, 20: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_done_tick  in  1  one-cycle strobe: a new scancode byte is present on rx_data.
- rx_data  in  8  scancode byte; sampled only when rx_done_tick=1.
- cmd_code  out  CODE_W  code of the last accepted make; holds its value between events.
- cmd_valid  out  1  one-cycle pulse: new make accepted, cmd_code updated in the same cycle.
- cmd_release  out  1  one-cycle pulse: the held key was released.
- key_held  out  1  level: a mapped key is currently held.
- err_tick  out  1  one-cycle pulse: prefix timeout abort.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, state IDLE, timeout counter 0, last_scan 0. Reset overrides any in-flight sequence.
- States: IDLE, GOT_F0, GOT_E0, GOT_E0F0. The FSM advances only on cycles where rx_done_tick=1, except for the timeout.
- Mapping, with ext bit prepended:
  - {0,16} -> 25, {0,1E} -> 25, {0,26} -> 25
  - {0,25} -> 26, {0,2E} -> 28
  - {1,75} -> 29, {1,72} -> 30
  - every other code -> 0, meaning unmapped.
- IDLE, byte b:
  - b=F0: go to GOT_F0.
  - b=E0 and EN_EXT=1: go to GOT_E0.
  - Otherwise b is a make with ext=0: run make handling.
- GOT_E0, byte b:
  - b=F0: go to GOT_E0F0.
  - b=E0: stay in GOT_E0.
  - Otherwise: make with ext=1, then go to IDLE.
- GOT_F0 and GOT_E0F0, byte b:
  - b=F0, or b=E0 in GOT_E0F0: stay in the current state.
  - Otherwise: break with ext=0 or ext=1 respectively, then go to IDLE.
- Make handling, code k:
  - Unmapped: no output change.
  - Mapped, key_held=1 and last_scan==k: typematic repeat, suppressed; no pulse.
  - Mapped, otherwise (including rollover to a different key while one is held): cmd_code <= map(k), cmd_valid=1, key_held <= 1, last_scan <= k.
- Break handling, code k:
  - key_held=1 and last_scan==k: key_held <= 0, cmd_release=1.
  - Otherwise: ignored.
- Latency: all outputs are registered and update in the cycle after the rx_done_tick edge. cmd_valid and cmd_release never assert together.
- Timeout:
  - The counter clears on every rx_done_tick and whenever the FSM is in IDLE.
  - In any prefix state it increments each cycle without a tick.
  - When it reaches TIMEOUT_CYC-1, the next cycle: FSM to IDLE, counter to 0, err_tick=1. key_held and cmd_code are unchanged.
  - If rx_done_tick coincides with the terminal count, the byte takes precedence and no err_tick is raised.
- Back-to-back rx_done_tick on consecutive cycles must be handled without loss.

Decomposition:
- Package ps2_pkg holds:
  - byte constants PS2_BREAK=8'hF0 and PS2_EXT=8'hE0;
  - 9-bit scan-key constants for the mapping table;
  - command code constants 25, 26, 28, 29, 30;
  - the 2-bit state encoding.
- One combinational sub-module, ps2_code_map: input 9-bit {ext,byte}, output CODE_W code, 0 = unmapped. It is instantiated once in ps2_cmd_fsm. The FSM, counter and output registers stay in ps2_cmd_fsm.

Test Plan:
- Reset, then byte 16 -> next cycle cmd_valid=1 for exactly 1 cycle, cmd_code=25, key_held=1.
- Bytes 16,16,16, then F0,16 -> exactly one cmd_valid; one cmd_release after the final 16; key_held=0; cmd_code stays 25.
- Make 25, then F0,2E -> no cmd_release, key_held=1. Then F0,25 -> cmd_release=1, key_held=0. Then 2E -> cmd_code=28.
- Extended keys:
  - E0,75 -> cmd_code=29.
  - E0,F0,75 -> cmd_release.
  - With EN_EXT=0, E0,75 -> no pulses at all.
- Timeout, with TIMEOUT_CYC=16:
  - F0, then no bytes -> err_tick on the 16th idle cycle.
  - Then 2E -> cmd_valid with code 28; the byte is not treated as a break.
  - Repeat with a byte landing exactly on the terminal cycle -> no err_tick.
- Make 16, send F0, assert reset for 1 cycle -> all outputs 0. Then 16 -> cmd_valid, code 25.
